// File: rtl/mdu_unit_if.sv
// Operand/result bundle between the EX stage and the multiply/divide unit.
// Master is the pipeline side, slave is the unit.
interface mdu_unit_if;
    logic [3:0]  md_op;
    logic [31:0] rs_val;
    logic [31:0] rt_val;
    logic        flush;
    logic        start;
    logic        busy;
    logic [31:0] hi_out;
    logic [31:0] lo_out;
    logic [31:0] md_out;

    modport master (
        output md_op, rs_val, rt_val, flush,
        input  start, busy, hi_out, lo_out, md_out
    );

    modport slave (
        input  md_op, rs_val, rt_val, flush,
        output start, busy, hi_out, lo_out, md_out
    );
endinterface

// File: rtl/mdu_unit.sv
// EX-stage multiply/divide unit owning HI/LO.
// Results are computed at accept and committed when the countdown expires.
module mdu_unit #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input logic       clk,
    input logic       reset,
    mdu_unit_if.slave md
);
    localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW   = $clog2(MAXC + 1);
    localparam logic [CW-1:0] MUL_N = CW'(MULT_CYCLES);
    localparam logic [CW-1:0] DIV_N = CW'(DIV_CYCLES);

    logic [CW-1:0] cnt_q, cnt_d;
    logic [31:0]   hi_q, hi_d, lo_q, lo_d;
    logic [31:0]   phi_q, phi_d, plo_q, plo_d;

    logic        is_mul, is_div, sgn, op_mthi, op_mtlo;
    logic        busy, start, done, wr_ok;
    logic [63:0] prod_s, prod_u;
    logic [31:0] a_mag, b_mag, b_safe, q_mag, r_mag, q_res, r_res;

    always_comb begin
        is_mul  = 1'b0;
        is_div  = 1'b0;
        sgn     = 1'b0;
        op_mthi = 1'b0;
        op_mtlo = 1'b0;
        case (md.md_op)
            4'd1:    begin is_mul = 1'b1; sgn = 1'b1; end
            4'd2:    is_mul = 1'b1;
            4'd3:    begin is_div = 1'b1; sgn = 1'b1; end
            4'd4:    is_div = 1'b1;
            4'd7:    op_mthi = 1'b1;
            4'd8:    op_mtlo = 1'b1;
            default: ;
        endcase
    end

    // Divide on magnitudes so the most-negative / -1 case needs no special path
    always_comb begin
        prod_s = {{32{md.rs_val[31]}}, md.rs_val} * {{32{md.rt_val[31]}}, md.rt_val};
        prod_u = {32'd0, md.rs_val} * {32'd0, md.rt_val};
        a_mag  = (sgn && md.rs_val[31]) ? -md.rs_val : md.rs_val;
        b_mag  = (sgn && md.rt_val[31]) ? -md.rt_val : md.rt_val;
        b_safe = (b_mag == 32'd0) ? 32'd1 : b_mag;
        q_mag  = a_mag / b_safe;
        r_mag  = a_mag % b_safe;
        q_res  = (sgn && (md.rs_val[31] ^ md.rt_val[31])) ? -q_mag : q_mag;
        r_res  = (sgn && md.rs_val[31]) ? -r_mag : r_mag;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
            hi_q  <= '0;
            lo_q  <= '0;
            phi_q <= '0;
            plo_q <= '0;
        end else begin
            cnt_q <= cnt_d;
            hi_q  <= hi_d;
            lo_q  <= lo_d;
            phi_q <= phi_d;
            plo_q <= plo_d;
        end
    end

    always_comb begin
        cnt_d = cnt_q;
        phi_d = phi_q;
        plo_d = plo_q;
        hi_d  = hi_q;
        lo_d  = lo_q;
        if (start) begin
            cnt_d = is_mul ? MUL_N : DIV_N;
            if (is_mul) begin
                {phi_d, plo_d} = sgn ? prod_s : prod_u;
            end else if (md.rt_val == 32'd0) begin
                // zero divisor commits the untouched HI/LO back
                phi_d = hi_q;
                plo_d = lo_q;
            end else begin
                phi_d = r_res;
                plo_d = q_res;
            end
        end else if (busy) begin
            cnt_d = cnt_q - CW'(1);
        end
        if (done) begin
            hi_d = phi_q;
            lo_d = plo_q;
        end
        if (wr_ok && op_mthi) hi_d = md.rs_val;
        if (wr_ok && op_mtlo) lo_d = md.rs_val;
    end

    always_comb begin
        busy      = (cnt_q != '0);
        done      = (cnt_q == CW'(1));
        wr_ok     = !md.flush && !busy;
        start     = (is_mul || is_div) && wr_ok;
        md.start  = start;
        md.busy   = busy;
        md.hi_out = hi_q;
        md.lo_out = lo_q;
        case (md.md_op)
            4'd5:    md.md_out = hi_q;
            4'd6:    md.md_out = lo_q;
            default: md.md_out = 32'd0;
        endcase
    end
endmodule

// File: tb/tb_mdu_unit.sv
// Self-checking bench for mdu_unit: vector table, hand-built corner
// sequences and random ops against an arithmetic reference model.
module tb_mdu_unit;
    localparam int MC = 5;
    localparam int DC = 10;

    logic clk;
    logic reset;
    int   n_cmp;
    int   n_err;
    logic [31:0] ref_hi, ref_lo;

    mdu_unit_if bus();

    mdu_unit #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
        .clk   (clk),
        .reset (reset),
        .md    (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  op;
        logic [31:0] rs;
        logic [31:0] rt;
        logic        fl;
        logic        ex_start;
        int          ex_busy;
        logic [31:0] ex_hi;
        logic [31:0] ex_lo;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Present one op for one cycle; sample combinational outputs mid-cycle
    task automatic do_op(input logic [3:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic fl,
                         output logic st, output logic [31:0] mo);
        @(negedge clk);
        bus.md_op  = op;
        bus.rs_val = a;
        bus.rt_val = b;
        bus.flush  = fl;
        #1;
        st = bus.start;
        mo = bus.md_out;
        @(negedge clk);
        bus.md_op = 4'd0;
        bus.flush = 1'b0;
    endtask

    task automatic count_busy(output int n);
        n = 0;
        while (bus.busy === 1'b1 && n < 100) begin
            n++;
            @(negedge clk);
        end
    endtask

    function automatic logic [31:0] rnd_val();
        case ($urandom_range(0, 5))
            0:       return 32'd0;
            1:       return 32'h8000_0000;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'd1;
            default: return $urandom;
        endcase
    endfunction

    // Architectural effect of an accepted op on HI/LO
    task automatic model(input logic [3:0] op, input logic [31:0] a,
                         input logic [31:0] b);
        longint          sa, sb, sq, sr;
        longint unsigned ua, ub, up;
        sa = $signed(a);
        sb = $signed(b);
        ua = a;
        ub = b;
        case (op)
            4'd1: begin
                sq = sa * sb;
                {ref_hi, ref_lo} = sq;
            end
            4'd2: begin
                up = ua * ub;
                {ref_hi, ref_lo} = up;
            end
            4'd3: if (b != 0) begin
                sq = sa / sb;
                sr = sa % sb;
                ref_lo = sq[31:0];
                ref_hi = sr[31:0];
            end
            4'd4: if (b != 0) begin
                ref_lo = a / b;
                ref_hi = a % b;
            end
            4'd7: ref_hi = a;
            4'd8: ref_lo = a;
            default: ;
        endcase
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        vec_t        tbl[$];
        logic        st;
        logic [31:0] mo;
        int          nb;
        bit          acc;
        logic [3:0]  op;
        logic [31:0] a, b;
        logic        fl;

        n_cmp = 0;
        n_err = 0;
        reset = 1'b0;
        bus.md_op  = 4'd0;
        bus.rs_val = 32'd0;
        bus.rt_val = 32'd0;
        bus.flush  = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b1;

        chk("reset_busy", {31'd0, bus.busy}, 32'd0);
        do_op(4'd5, 32'd0, 32'd0, 1'b0, st, mo);
        chk("reset_mfhi", mo, 32'd0);
        do_op(4'd6, 32'd0, 32'd0, 1'b0, st, mo);
        chk("reset_mflo", mo, 32'd0);

        tbl.push_back('{4'd1, 32'hFFFF_FFFE, 32'd3, 1'b0, 1'b1, MC, 32'hFFFF_FFFF, 32'hFFFF_FFFA});
        tbl.push_back('{4'd2, 32'hFFFF_FFFE, 32'd3, 1'b0, 1'b1, MC, 32'h0000_0002, 32'hFFFF_FFFA});
        tbl.push_back('{4'd3, 32'hFFFF_FFF9, 32'd2, 1'b0, 1'b1, DC, 32'hFFFF_FFFF, 32'hFFFF_FFFD});
        tbl.push_back('{4'd7, 32'h11, 32'd0, 1'b0, 1'b0, 0, 32'h11, 32'hFFFF_FFFD});
        tbl.push_back('{4'd8, 32'h22, 32'd0, 1'b0, 1'b0, 0, 32'h11, 32'h22});
        tbl.push_back('{4'd4, 32'd7, 32'd0, 1'b0, 1'b1, DC, 32'h11, 32'h22});
        tbl.push_back('{4'd1, 32'd9, 32'd9, 1'b1, 1'b0, 0, 32'h11, 32'h22});
        tbl.push_back('{4'd8, 32'hDEAD, 32'd0, 1'b1, 1'b0, 0, 32'h11, 32'h22});
        tbl.push_back('{4'd3, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b1, DC, 32'h0, 32'h8000_0000});
        tbl.push_back('{4'd3, 32'd7, 32'hFFFF_FFFE, 1'b0, 1'b1, DC, 32'h1, 32'hFFFF_FFFD});
        tbl.push_back('{4'd9, 32'd5, 32'd5, 1'b0, 1'b0, 0, 32'h1, 32'hFFFF_FFFD});
        tbl.push_back('{4'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b1, MC, 32'hFFFF_FFFE, 32'h1});

        foreach (tbl[i]) begin
            do_op(tbl[i].op, tbl[i].rs, tbl[i].rt, tbl[i].fl, st, mo);
            chk($sformatf("v%0d_start", i), {31'd0, st}, {31'd0, tbl[i].ex_start});
            count_busy(nb);
            chk($sformatf("v%0d_busy", i), nb, tbl[i].ex_busy);
            chk($sformatf("v%0d_hi", i), bus.hi_out, tbl[i].ex_hi);
            chk($sformatf("v%0d_lo", i), bus.lo_out, tbl[i].ex_lo);
            do_op(4'd5, 32'd0, 32'd0, 1'b0, st, mo);
            chk($sformatf("v%0d_mfhi", i), mo, tbl[i].ex_hi);
            do_op(4'd6, 32'd0, 32'd0, 1'b0, st, mo);
            chk($sformatf("v%0d_mflo", i), mo, tbl[i].ex_lo);
        end

        // MTHI at busy cycle 3 and flush at cycle 4 of an in-flight DIV
        do_op(4'd3, 32'd100, 32'd7, 1'b0, st, mo);
        chk("inj_start", {31'd0, st}, 32'd1);
        nb = 0;
        while (bus.busy === 1'b1 && nb < 100) begin
            nb++;
            bus.md_op  = (nb == 3) ? 4'd7 : 4'd0;
            bus.rs_val = 32'h5;
            bus.flush  = (nb == 4);
            #1;
            if (nb == 3) chk("inj_mthi_start", {31'd0, bus.start}, 32'd0);
            @(negedge clk);
        end
        bus.md_op = 4'd0;
        bus.flush = 1'b0;
        chk("inj_busy", nb, DC);
        chk("inj_hi", bus.hi_out, 32'd2);
        chk("inj_lo", bus.lo_out, 32'd14);

        // Async reset in the middle of a MULT
        do_op(4'd1, 32'd1000, 32'd1000, 1'b0, st, mo);
        @(negedge clk);
        #2 reset = 1'b0;
        #1;
        chk("arst_busy", {31'd0, bus.busy}, 32'd0);
        chk("arst_hi", bus.hi_out, 32'd0);
        chk("arst_lo", bus.lo_out, 32'd0);
        @(negedge clk);
        #2 reset = 1'b1;
        repeat (8) @(negedge clk);
        chk("arst_late_busy", {31'd0, bus.busy}, 32'd0);
        chk("arst_late_hi", bus.hi_out, 32'd0);
        chk("arst_late_lo", bus.lo_out, 32'd0);

        ref_hi = 32'd0;
        ref_lo = 32'd0;
        for (int it = 0; it < 250; it++) begin
            op = 4'($urandom_range(0, 15));
            a  = rnd_val();
            b  = rnd_val();
            fl = ($urandom_range(0, 7) == 0);
            acc = (op >= 4'd1 && op <= 4'd4 && !fl);
            do_op(op, a, b, fl, st, mo);
            chk($sformatf("r%0d_start", it), {31'd0, st}, {31'd0, acc});
            chk($sformatf("r%0d_mdout", it), mo,
                (op == 4'd5) ? ref_hi : (op == 4'd6) ? ref_lo : 32'd0);
            count_busy(nb);
            chk($sformatf("r%0d_busy", it), nb,
                !acc ? 0 : (op <= 4'd2) ? MC : DC);
            if (!fl) model(op, a, b);
            chk($sformatf("r%0d_hi", it), bus.hi_out, ref_hi);
            chk($sformatf("r%0d_lo", it), bus.lo_out, ref_lo);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
